// File: rtl/bcd_pkg.sv
// Shared BCD widths, limits and decoder state encoding; used by both encoder and decoder sides.
// Combinational definitions only, no latency or backpressure of its own.
package bcd_pkg;

  localparam int BCD_W    = 4;
  localparam int ONEHOT_W = 10;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

endpackage

// File: rtl/bcd_to_onehot.sv
// Combinational BCD to one-hot digit decode with illegal-code flag (codes 10..15 give all-zero).
// Zero latency, no handshake.
module bcd_to_onehot
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0]    code,
  output logic [ONEHOT_W-1:0] onehot,
  output logic                illegal
);

  always_comb begin
    illegal = (code > BCD_MAX);
    onehot  = '0;
    if (!illegal) begin
      onehot = ONEHOT_W'(1) << code;
    end
  end

endmodule

// File: rtl/bcd_decoder_hold.sv
// Registered BCD decoder: one-hot digit held HOLD_CYCLES cycles, illegal codes flagged and counted.
// One-cycle latency; cin_ready only in IDLE or the last HOLD cycle, and never while en is low.
module bcd_decoder_hold
  import bcd_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int ERR_W       = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                cin_valid,
  output logic                cin_ready,
  input  logic [BCD_W-1:0]    cin,
  output logic [ONEHOT_W-1:0] cout,
  output logic                cout_valid,
  output logic                err,
  output logic [ERR_W-1:0]    err_cnt
);

  localparam int HOLD_W = 8;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  state_t              state, state_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
  logic [ONEHOT_W-1:0] cout_nxt;
  logic                cout_valid_nxt;
  logic                err_nxt;
  logic [ERR_W-1:0]    err_cnt_nxt;
  logic [ONEHOT_W-1:0] dec_onehot;
  logic                dec_illegal;
  logic                accept;

  bcd_to_onehot u_dec (
    .code    (cin),
    .onehot  (dec_onehot),
    .illegal (dec_illegal)
  );

  // hold_cnt is always zero in IDLE, so the last HOLD cycle looks like IDLE to the source.
  assign cin_ready = en & ~rst & ((state == IDLE) | (hold_cnt == '0));
  assign accept    = cin_valid & cin_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      cout       <= '0;
      cout_valid <= 1'b0;
      err        <= 1'b0;
      err_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      hold_cnt   <= hold_nxt;
      cout       <= cout_nxt;
      cout_valid <= cout_valid_nxt;
      err        <= err_nxt;
      err_cnt    <= err_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    hold_nxt       = hold_cnt;
    cout_nxt       = cout;
    cout_valid_nxt = cout_valid;
    err_nxt        = 1'b0;
    err_cnt_nxt    = err_cnt;

    if (accept) begin
      if (dec_illegal) begin
        // An illegal code also drops a digit still showing in its last hold cycle.
        state_nxt      = IDLE;
        hold_nxt       = '0;
        cout_nxt       = '0;
        cout_valid_nxt = 1'b0;
        err_nxt        = 1'b1;
        if (err_cnt != '1) begin
          err_cnt_nxt = err_cnt + 1'b1;
        end
      end else begin
        state_nxt      = HOLD;
        hold_nxt       = HOLD_LOAD;
        cout_nxt       = dec_onehot;
        cout_valid_nxt = 1'b1;
      end
    end else if (en && (state == HOLD)) begin
      if (hold_cnt != '0) begin
        hold_nxt = hold_cnt - 1'b1;
      end else begin
        state_nxt      = IDLE;
        cout_nxt       = '0;
        cout_valid_nxt = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bcd_decoder_hold.sv
// Scoreboard bench for bcd_decoder_hold: driver queues expected outputs on accept,
// monitor pops and compares one cycle later; directed checks cover hold length, enable and reset.
module tb_bcd_decoder_hold;

  localparam int HOLD = 4;
  localparam int EW   = 2;
  localparam int EMAX = (1 << EW) - 1;
  localparam logic [9:0] SWEEP [10] = '{
    10'b0000000001, 10'b0000000010, 10'b0000000100, 10'b0000001000, 10'b0000010000,
    10'b0000100000, 10'b0001000000, 10'b0010000000, 10'b0100000000, 10'b1000000000
  };

  typedef struct {
    logic [9:0]    cout;
    logic          vld;
    logic          err;
    logic [EW-1:0] cnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          cin_valid = 1'b0;
  logic          cin_ready;
  logic [3:0]    cin = 4'd0;
  logic [9:0]    cout;
  logic          cout_valid;
  logic          err;
  logic [EW-1:0] err_cnt;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   exp_errs = 0;
  bit   mon_on = 1'b0;
  bit   watch_vld = 1'b0;
  int   vld_drops = 0;
  int   err_stray = 0;
  int   multihot = 0;

  bcd_decoder_hold #(.HOLD_CYCLES(HOLD), .ERR_W(EW)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .cin_valid  (cin_valid),
    .cin_ready  (cin_ready),
    .cin        (cin),
    .cout       (cout),
    .cout_valid (cout_valid),
    .err        (err),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [3:0] code, input logic [9:0] ecout, output int waited);
    exp_t e;
    bit   got;
    @(negedge clk);
    cin       = code;
    cin_valid = 1'b1;
    waited    = 0;
    got       = 1'b0;
    while (!got && waited < 50) begin
      @(posedge clk);
      waited++;
      if (cin_ready) begin
        got    = 1'b1;
        e.cout = ecout;
        e.vld  = (code <= 4'd9);
        e.err  = (code > 4'd9);
        if (code > 4'd9 && exp_errs < EMAX) exp_errs++;
        e.cnt  = EW'(exp_errs);
        sb.push_back(e);
      end
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL send_timeout code=%0d: cin_ready=%b, expected accept within 50 cycles", code, cin_ready);
    end
    #1 cin_valid = 1'b0;
  endtask

  task automatic measure(output int n, output logic [15:0] rmask);
    n     = 0;
    rmask = '0;
    while (cout_valid && n < 40) begin
      if (n < 16) rmask[n] = cin_ready;
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (cout_valid && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(name, cout_valid, 0);
  endtask

  // Monitor: an accept seen at an edge must show its expected result 1 time unit later.
  logic acc;
  exp_t mon_e;
  initial begin
    forever begin
      @(posedge clk);
      acc = mon_on && cin_valid && cin_ready;
      #1;
      if (mon_on) begin
        if ($countones(cout) > 1) multihot++;
        if (watch_vld && !cout_valid) vld_drops++;
        if (acc) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_empty: output after accept, no expected entry queued");
          end else begin
            mon_e = sb.pop_front();
            check("sb_cout", cout, mon_e.cout);
            check("sb_cout_valid", cout_valid, mon_e.vld);
            check("sb_err", err, mon_e.err);
            check("sb_err_cnt", err_cnt, mon_e.cnt);
          end
        end else if (err !== 1'b0) begin
          err_stray++;
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w;
    int          n;
    int          rdy_bad;
    logic [15:0] rm;

    // Reset asserted mid-cycle, before any clock edge.
    #2 rst = 1'b1;
    #1;
    check("rst_cout", cout, 0);
    check("rst_cout_valid", cout_valid, 0);
    check("rst_err", err, 0);
    check("rst_err_cnt", err_cnt, 0);
    en = 1'b1;
    #1;
    check("rst_ready_low", cin_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_rst", cin_ready, 1);
    mon_on = 1'b1;

    // Legal sweep: each digit held 4 cycles, ready only in the last one.
    for (int i = 0; i < 10; i++) begin
      send(4'(i), SWEEP[i], w);
      measure(n, rm);
      check($sformatf("hold_len_%0d", i), n, HOLD);
      check($sformatf("ready_mask_%0d", i), rm, 16'b1000);
    end

    // Back-to-back: 7 accepted in the last hold cycle of 3.
    send(4'd3, 10'b0000001000, w);
    watch_vld = 1'b1;
    send(4'd7, 10'b0010000000, w);
    check("b2b_wait", w, 4);
    @(posedge clk);
    #1;
    watch_vld = 1'b0;
    check("b2b_vld_drops", vld_drops, 0);
    wait_idle("b2b_idle");

    // Illegal codes, then a legal one.
    send(4'hA, 10'b0, w);
    send(4'hF, 10'b0, w);
    @(posedge clk);
    #1;
    check("illegal_err_cnt", err_cnt, 2);
    check("illegal_err_low", err, 0);
    send(4'd5, 10'b0000100000, w);
    wait_idle("after_illegal_idle");

    // Enable freeze: en low for 3 edges during HOLD.
    send(4'd2, 10'b0000000100, w);
    n       = 0;
    rdy_bad = 0;
    while (cout_valid && n < 40) begin
      n++;
      if (n == 4) check("freeze_cout", cout, 10'b0000000100);
      @(negedge clk);
      if (n == 1) en = 1'b0;
      if (n == 4) en = 1'b1;
      if (!en && cin_ready) rdy_bad++;
      @(posedge clk);
      #1;
    end
    check("freeze_len", n, 7);
    check("freeze_ready_low", rdy_bad, 0);

    // Saturation of the 2-bit error counter.
    for (int i = 0; i < 5; i++) begin
      send(4'(10 + i), 10'b0, w);
    end
    @(posedge clk);
    #1;
    check("sat_err_cnt", err_cnt, 3);

    // Reset mid-HOLD clears outputs without a clock edge.
    send(4'd8, 10'b0100000000, w);
    @(negedge clk);
    #1;
    check("pre_rst_cout_valid", cout_valid, 1);
    rst = 1'b1;
    #1;
    check("midrst_cout", cout, 0);
    check("midrst_cout_valid", cout_valid, 0);
    check("midrst_err_cnt", err_cnt, 0);
    check("midrst_ready", cin_ready, 0);
    exp_errs = 0;
    @(negedge clk);
    rst = 1'b0;
    send(4'd9, 10'b1000000000, w);
    wait_idle("final_idle");

    check("sb_drained", sb.size(), 0);
    check("onehot_violations", multihot, 0);
    check("err_stray_pulses", err_stray, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
